// File: rtl/conv1_sched.sv
// Layer-1 convolution window scheduler: walks kern/row/col, tracks MAC latency.
// Optional stall counter output enabled by CONV1_SCHED_PERF_EN.
module conv1_sched #(
    parameter int BITWIDTH = 8,
    parameter int MAC_LAT  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stall,
    output logic        busy,
    output logic        done,
    output logic        issue,
    output logic [4:0]  win_row,
    output logic [4:0]  win_col,
    output logic        kern_sel,
    output logic        pipe_en,
    output logic        fm_we,
    output logic [10:0] fm_addr
`ifdef CONV1_SCHED_PERF_EN
    ,
    output logic [15:0] stall_cycles
`endif
);

    if (BITWIDTH < 1 || MAC_LAT < 1 || MAC_LAT > 8) begin : g_param_chk
        $error("conv1_sched: illegal parameter value");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nx;

    logic [MAC_LAT-1:0] dl_v;
    logic [10:0]        dl_a [MAC_LAT];
    logic               dl_upper;
    logic               last_issue;

    assign busy    = (state == RUN) || (state == DRAIN);
    assign done    = (state == DONE);
    assign issue   = (state == RUN) && !stall;
    assign pipe_en = busy && !stall;
    assign fm_we   = dl_v[MAC_LAT-1] && pipe_en;
    assign fm_addr = dl_a[MAC_LAT-1];

    assign last_issue = issue && kern_sel &&
                        (win_row == 5'd27) && (win_col == 5'd27);

    // Any result still in flight ahead of the output stage
    always_comb begin
        dl_upper = 1'b0;
        for (int i = 0; i < MAC_LAT - 1; i++) begin
            dl_upper = dl_upper | dl_v[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_issue) state_nx = DRAIN;
            DRAIN:   if (fm_we && !dl_upper) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_col  <= 5'd0;
            win_row  <= 5'd0;
            kern_sel <= 1'b0;
        end else if (issue) begin
            if (win_col == 5'd27) begin
                win_col <= 5'd0;
                if (win_row == 5'd27) begin
                    win_row  <= 5'd0;
                    kern_sel <= ~kern_sel;
                end else begin
                    win_row <= win_row + 5'd1;
                end
            end else begin
                win_col <= win_col + 5'd1;
            end
        end
    end

    // Delay line mirrors the MAC pipeline; it only moves when the datapath does
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_v <= '0;
            for (int i = 0; i < MAC_LAT; i++) begin
                dl_a[i] <= 11'd0;
            end
        end else if (pipe_en) begin
            dl_v[0] <= issue;
            dl_a[0] <= {kern_sel, win_row, win_col};
            for (int i = 1; i < MAC_LAT; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
            end
        end
    end

`ifdef CONV1_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (state == IDLE && start) begin
            stall_cycles <= 16'd0;
        end else if (busy && stall && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv1_sched.sv
// Bench for conv1_sched: index-based reference model plus directed scenarios.
// Define CONV1_SCHED_PERF_EN to also check the stall counter.
module tb_conv1_sched;

    localparam int LAT = 2;
    localparam int NW  = 1568;

    logic        clk = 1'b0;
    logic        rst, start, stall;
    logic        busy, done, issue, kern_sel, pipe_en, fm_we;
    logic [4:0]  win_row, win_col;
    logic [10:0] fm_addr;
`ifdef CONV1_SCHED_PERF_EN
    logic [15:0] stall_cycles;
`endif

    conv1_sched #(.BITWIDTH(8), .MAC_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .busy(busy), .done(done), .issue(issue),
        .win_row(win_row), .win_col(win_col),
        .kern_sel(kern_sel), .pipe_en(pipe_en),
        .fm_we(fm_we), .fm_addr(fm_addr)
`ifdef CONV1_SCHED_PERF_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int npass = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        nchk++;
        if (a === e) npass++;
        else $display("FAIL %s: got %0h want %0h", nm, a, e);
    endtask

    // Window n of a pass -> {kern,row,col}
    function automatic logic [10:0] pos(input int n);
        int m;
        m = n % NW;
        return 11'((m / 784) * 1024 + ((m % 784) / 28) * 32 + m % 28);
    endfunction

    int     phase = 0;
    int     issued = 0;
    int     written = 0;
    longint en = 0;
    int     q_idx[$];
    longint q_e[$];

    int tcyc, pass_iss, pass_wr, done_cnt, tot_wr;
    int first_iss, last_iss, first_we, last_we, done_cyc;
    logic [10:0] iss_pos [NW];
    logic [10:0] wr_addr [NW];

    initial begin
        tcyc = 0; pass_iss = 0; pass_wr = 0; done_cnt = 0; tot_wr = 0;
        first_iss = -1; last_iss = -1; first_we = -1;
        last_we = -1; done_cyc = -1;
    end

    always @(negedge clk) begin
        logic   act, e_iss, e_we;
        longint en_now;
        logic [10:0] p;
        if (rst) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_issue", 32'(issue), 0);
            chk("rst_pipe", 32'(pipe_en), 0);
            chk("rst_we", 32'(fm_we), 0);
            chk("rst_win", {kern_sel, win_row, win_col}, 0);
            chk("rst_addr", 32'(fm_addr), 0);
            phase = 0; issued = 0; written = 0;
            q_idx.delete(); q_e.delete();
        end else begin
            act    = (phase == 1);
            en_now = en + ((act && !stall) ? 1 : 0);
            e_iss  = act && issued < NW && !stall;
            e_we   = act && !stall && q_e.size() > 0 &&
                     q_e[0] + LAT == en_now;
            p = pos(issued);
            chk("busy", 32'(busy), 32'(act));
            chk("done", 32'(done), 32'(phase == 2));
            chk("issue", 32'(issue), 32'(e_iss));
            chk("pipe_en", 32'(pipe_en), 32'(act && !stall));
            chk("win", {kern_sel, win_row, win_col}, 32'(p));
            chk("fm_we", 32'(fm_we), 32'(e_we));
            if (e_we) chk("fm_addr", 32'(fm_addr), 32'(pos(q_idx[0])));
            tcyc++;
            if (issue === 1'b1) begin
                if (pass_iss < NW) iss_pos[pass_iss] = {kern_sel, win_row, win_col};
                if (pass_iss == 0) first_iss = tcyc;
                last_iss = tcyc;
                pass_iss++;
            end
            if (fm_we === 1'b1) begin
                if (pass_wr < NW) wr_addr[pass_wr] = fm_addr;
                if (pass_wr == 0) first_we = tcyc;
                last_we = tcyc;
                pass_wr++;
                tot_wr++;
            end
            if (done === 1'b1) begin
                done_cyc = tcyc;
                done_cnt++;
            end
            en = en_now;
            if (e_iss) begin
                q_idx.push_back(issued);
                q_e.push_back(en_now);
                issued++;
            end
            if (e_we) begin
                void'(q_idx.pop_front());
                void'(q_e.pop_front());
                written++;
            end
            if (phase == 0 && start) begin
                phase = 1; issued = 0; written = 0;
                tcyc = 0; pass_iss = 0; pass_wr = 0;
                first_iss = -1; last_iss = -1; first_we = -1;
                last_we = -1; done_cyc = -1;
            end else if (phase == 1 && written == NW) begin
                phase = 2;
            end else if (phase == 2) begin
                phase = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int budget);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < budget; i++) begin
            step();
            if (done_cnt > d0) break;
        end
        chk("done_seen", 32'(done_cnt > d0), 1);
        repeat (3) step();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        int d0, w0;
        rst = 1'b1; start = 1'b0; stall = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // stall while idle is harmless
        stall = 1'b1;
        repeat (4) step();
        stall = 1'b0;

        // nominal pass
        pulse_start();
        wait_done(2000);
        chk("first_iss", first_iss, 1);
        chk("last_iss", last_iss, 1568);
        chk("first_we", first_we, 1 + LAT);
        chk("last_we", last_we, 1568 + LAT);
        chk("done_cyc", done_cyc, 1569 + LAT);
        chk("n_writes", pass_wr, NW);
        chk("addr_w1", 32'(wr_addr[0]), 32'h000);
        chk("addr_w28", 32'(wr_addr[27]), 32'h01B);
        chk("addr_w29", 32'(wr_addr[28]), 32'h020);
        chk("addr_w785", 32'(wr_addr[784]), 32'h400);
        chk("addr_w1568", 32'(wr_addr[1567]), 32'h77B);
`ifdef CONV1_SCHED_PERF_EN
        chk("perf_zero", 32'(stall_cycles), 0);
`endif

        // 10-cycle stall after the first 100 issues
        pulse_start();
        repeat (100) step();
        stall = 1'b1;
        repeat (10) step();
        stall = 1'b0;
        wait_done(2000);
        chk("pre_stall_pos", 32'(iss_pos[99]), 32'h06F);
        chk("resume_pos", 32'(iss_pos[100]), 32'h070);
        chk("stall_done_cyc", done_cyc, 1579 + LAT);
        chk("stall_writes", pass_wr, NW);
`ifdef CONV1_SCHED_PERF_EN
        chk("perf_stall", 32'(stall_cycles), 10);
`endif

        // start re-pulsed mid-pass is ignored
        d0 = done_cnt;
        pulse_start();
        repeat (499) step();
        pulse_start();
        wait_done(2000);
        repeat (5) step();
        chk("restart_writes", pass_wr, NW);
        chk("restart_dones", done_cnt - d0, 1);
        chk("restart_idle", 32'(busy), 0);

        // reset mid-pass
        pulse_start();
        repeat (799) step();
        rst = 1'b1;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_issue", 32'(issue), 0);
        chk("async_we", 32'(fm_we), 0);
        chk("async_win", {kern_sel, win_row, win_col}, 0);
        repeat (2) step();
        rst = 1'b0;
        w0 = tot_wr;
        repeat (20) step();
        chk("post_rst_nowr", tot_wr - w0, 0);
        chk("post_rst_idle", 32'(busy), 0);
        pulse_start();
        wait_done(2000);
        chk("rerun_first", 32'(iss_pos[0]), 32'h000);
        chk("rerun_writes", pass_wr, NW);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
